// File: rtl/ge_p1p1_to_p3_if.sv
// Request/acknowledge port to the shared 320-bit field multiplier.
// The converter is the master; the multiplier is the slave.
interface ge_p1p1_to_p3_if;
    logic         mul_req;
    logic [319:0] mul_a;
    logic [319:0] mul_b;
    logic         mul_ack;
    logic [319:0] mul_r;

    modport master (
        output mul_req, mul_a, mul_b,
        input  mul_ack, mul_r
    );

    modport slave (
        input  mul_req, mul_a, mul_b,
        output mul_ack, mul_r
    );
endinterface

// File: rtl/ge_p1p1_to_p3.sv
// ge_p1p1 -> ge_p3 converter issuing four products to a shared multiplier.
// Define GE_P1P1_TO_P3_P2_MODE_EN for ge_p2 output (three products, r_T = 0).
module ge_p1p1_to_p3 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    input  logic [319:0] p_X,
    input  logic [319:0] p_Y,
    input  logic [319:0] p_Z,
    input  logic [319:0] p_T,
    output logic [319:0] r_X,
    output logic [319:0] r_Y,
    output logic [319:0] r_Z,
    output logic [319:0] r_T,
    ge_p1p1_to_p3_if.master mul
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

`ifdef GE_P1P1_TO_P3_P2_MODE_EN
    localparam logic [1:0] LAST_K = 2'd2;
`else
    localparam logic [1:0] LAST_K = 2'd3;
`endif

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_k;
    logic [319:0] r_px, r_py, r_pz, r_pt;
    logic [319:0] r_t0, r_t1;
`ifndef GE_P1P1_TO_P3_P2_MODE_EN
    logic [319:0] r_t2;
`endif
    logic         w_accept;
    logic         w_fire;
    logic         w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_fire   = (r_state == S_MUL) && mul.mul_ack;
    assign w_last   = (r_k == LAST_K);

    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mul.mul_req = 1'b0;
        mul.mul_a   = '0;
        mul.mul_b   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_MUL;
            end
            S_MUL: begin
                busy        = 1'b1;
                mul.mul_req = 1'b1;
                unique case (r_k)
                    2'd0: begin mul.mul_a = r_px; mul.mul_b = r_pt; end
                    2'd1: begin mul.mul_a = r_py; mul.mul_b = r_pz; end
                    2'd2: begin mul.mul_a = r_pz; mul.mul_b = r_pt; end
                    2'd3: begin mul.mul_a = r_px; mul.mul_b = r_py; end
                endcase
                if (mul.mul_ack && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k  <= '0;
            r_px <= '0;
            r_py <= '0;
            r_pz <= '0;
            r_pt <= '0;
        end else if (w_accept) begin
            r_k  <= '0;
            r_px <= p_X;
            r_py <= p_Y;
            r_pz <= p_Z;
            r_pt <= p_T;
        end else if (w_fire && !w_last) begin
            r_k <= r_k + 2'd1;
        end
    end

    // The last product feeds the outputs directly, so it needs no temp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t0 <= '0;
            r_t1 <= '0;
`ifndef GE_P1P1_TO_P3_P2_MODE_EN
            r_t2 <= '0;
`endif
        end else if (w_fire) begin
            if (r_k == 2'd0) r_t0 <= mul.mul_r;
            if (r_k == 2'd1) r_t1 <= mul.mul_r;
`ifndef GE_P1P1_TO_P3_P2_MODE_EN
            if (r_k == 2'd2) r_t2 <= mul.mul_r;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_X <= '0;
            r_Y <= '0;
            r_Z <= '0;
            r_T <= '0;
        end else if (w_fire && w_last) begin
            r_X <= r_t0;
            r_Y <= r_t1;
`ifdef GE_P1P1_TO_P3_P2_MODE_EN
            r_Z <= mul.mul_r;
            r_T <= '0;
`else
            r_Z <= r_t2;
            r_T <= mul.mul_r;
`endif
        end
    end

endmodule

// File: tb/tb_ge_p1p1_to_p3.sv
// Directed bench for ge_p1p1_to_p3 with a behavioural multiplier.
// Honours GE_P1P1_TO_P3_P2_MODE_EN for the three-product variant.
module tb_ge_p1p1_to_p3;

`ifdef GE_P1P1_TO_P3_P2_MODE_EN
    localparam int NP = 3;
`else
    localparam int NP = 4;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic [319:0] p_X, p_Y, p_Z, p_T;
    logic [319:0] r_X, r_Y, r_Z, r_T;

    ge_p1p1_to_p3_if mif ();

    ge_p1p1_to_p3 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .p_X   (p_X),
        .p_Y   (p_Y),
        .p_Z   (p_Z),
        .p_T   (p_T),
        .r_X   (r_X),
        .r_Y   (r_Y),
        .r_Z   (r_Z),
        .r_T   (r_T),
        .mul   (mif)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    logic [319:0] oa [4];
    logic [319:0] ob [4];
    int o_first, o_done, o_busy0, o_nprod;
    bit o_unst, o_rchg, o_to;

    function automatic logic [319:0] fmul(input logic [319:0] a,
                                          input logic [319:0] b);
        return a * b;
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Runs one conversion; the multiplier acks product k after lat[k] cycles.
    task automatic drive_conv(input logic [319:0] x, input logic [319:0] y,
                              input logic [319:0] z, input logic [319:0] t,
                              input int l0, input int l1,
                              input int l2, input int l3, input bit pert);
        int lat [4];
        int k, cnt;
        logic [319:0] hx, hy, hz, ht;
        lat = '{l0, l1, l2, l3};
        o_first = -1; o_done = -1; o_unst = 0; o_rchg = 0; o_to = 0;
        k = 0; cnt = 0;
        @(negedge clk);
        o_busy0 = busy;
        hx = r_X; hy = r_Y; hz = r_Z; ht = r_T;
        start = 1'b1;
        p_X = x; p_Y = y; p_Z = z; p_T = t;
        @(posedge clk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            start = pert && (n == 1 || n == 3);
            if (pert && n == 1) begin
                p_X = rnd320(); p_Y = rnd320();
                p_Z = rnd320(); p_T = rnd320();
            end
            mif.mul_ack = 1'b0;
            if (done) begin
                o_done = n;
                break;
            end
            if (r_X !== hx || r_Y !== hy || r_Z !== hz || r_T !== ht)
                o_rchg = 1;
            if (mif.mul_req && k < 4) begin
                if (cnt == 0) begin
                    oa[k] = mif.mul_a;
                    ob[k] = mif.mul_b;
                    if (o_first < 0) o_first = n;
                end else if (mif.mul_a !== oa[k] || mif.mul_b !== ob[k]) begin
                    o_unst = 1;
                end
                cnt++;
                if (cnt >= lat[k]) begin
                    mif.mul_ack = 1'b1;
                    mif.mul_r   = fmul(oa[k], ob[k]);
                    k++;
                    cnt = 0;
                end
            end
            @(posedge clk);
        end
        if (o_done < 0) o_to = 1;
        o_nprod = k;
        start = 1'b0;
        mif.mul_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        p_X = '0; p_Y = '0; p_Z = '0; p_T = '0;
        mif.mul_ack = 1'b0;
        mif.mul_r = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || mif.mul_req !== 1'b0) begin
            nmis++;
            $display("FAIL reset_ctl got busy=%b done=%b req=%b want 0 0 0",
                     busy, done, mif.mul_req);
        end
        nvec++;
        if (mif.mul_a !== '0 || mif.mul_b !== '0) begin
            nmis++;
            $display("FAIL reset_ops got a=%h b=%h want 0", mif.mul_a, mif.mul_b);
        end
        nvec++;
        if (r_X !== '0 || r_Y !== '0 || r_Z !== '0 || r_T !== '0) begin
            nmis++;
            $display("FAIL reset_r got nonzero r_* want 0");
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [319:0] ea [4];
        logic [319:0] eb [4];
        ea = '{320'd2, 320'd3, 320'd5, 320'd2};
        eb = '{320'd7, 320'd5, 320'd7, 320'd3};
        drive_conv(320'd2, 320'd3, 320'd5, 320'd7, 1, 1, 1, 1, 0);
        nvec++;
        if (o_to) begin
            nmis++;
            $display("FAIL basic_timeout got no done want done");
        end
        nvec++;
        if (o_nprod !== NP) begin
            nmis++;
            $display("FAIL basic_nprod got %0d want %0d", o_nprod, NP);
        end
        for (int i = 0; i < NP; i++) begin
            nvec++;
            if (oa[i] !== ea[i] || ob[i] !== eb[i]) begin
                nmis++;
                $display("FAIL basic_ops%0d got (%0d,%0d) want (%0d,%0d)",
                         i, oa[i], ob[i], ea[i], eb[i]);
            end
        end
        nvec++;
        if (o_first !== 1 || o_done !== 1 + NP) begin
            nmis++;
            $display("FAIL basic_timing got req@%0d done@%0d want 1 %0d",
                     o_first, o_done, 1 + NP);
        end
        nvec++;
        if (r_X !== 320'd14 || r_Y !== 320'd15 || r_Z !== 320'd35) begin
            nmis++;
            $display("FAIL basic_rxyz got %0d %0d %0d want 14 15 35",
                     r_X, r_Y, r_Z);
        end
        nvec++;
`ifdef GE_P1P1_TO_P3_P2_MODE_EN
        if (r_T !== 320'd0) begin
            nmis++;
            $display("FAIL basic_rT got %0d want 0", r_T);
        end
`else
        if (r_T !== 320'd6) begin
            nmis++;
            $display("FAIL basic_rT got %0d want 6", r_T);
        end
`endif
        nvec++;
        if (busy !== 1'b1) begin
            nmis++;
            $display("FAIL basic_busy_done got %b want 1", busy);
        end
        @(negedge clk);
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nmis++;
            $display("FAIL basic_after got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_latency();
        logic [319:0] x, y, z, t;
        int span;
        x = rnd320(); y = rnd320(); z = rnd320(); t = rnd320();
        span = (NP == 4) ? 11 : 9;
        drive_conv(x, y, z, t, 3, 1, 5, 2, 0);
        nvec++;
        if (o_to || o_done - o_first !== span) begin
            nmis++;
            $display("FAIL lat_span got %0d want %0d", o_done - o_first, span);
        end
        nvec++;
        if (o_unst) begin
            nmis++;
            $display("FAIL lat_stable got unstable operands want stable");
        end
        nvec++;
        if (o_rchg) begin
            nmis++;
            $display("FAIL lat_rhold got r_* changed before done want held");
        end
        nvec++;
        if (r_X !== fmul(x, t) || r_Y !== fmul(y, z) || r_Z !== fmul(z, t)) begin
            nmis++;
            $display("FAIL lat_result got rX=%h want %h", r_X, fmul(x, t));
        end
    endtask

    task automatic test_capture();
        logic [319:0] x, y, z, t;
        int extra;
        x = rnd320(); y = rnd320(); z = rnd320(); t = rnd320();
        drive_conv(x, y, z, t, 1, 1, 1, 1, 1);
        nvec++;
        if (o_to || o_done !== 1 + NP) begin
            nmis++;
            $display("FAIL cap_timing got done@%0d want %0d", o_done, 1 + NP);
        end
        nvec++;
        if (r_X !== fmul(x, t) || r_Y !== fmul(y, z) || r_Z !== fmul(z, t)) begin
            nmis++;
            $display("FAIL cap_result got rY=%h want %h", r_Y, fmul(y, z));
        end
`ifndef GE_P1P1_TO_P3_P2_MODE_EN
        nvec++;
        if (r_T !== fmul(x, y)) begin
            nmis++;
            $display("FAIL cap_rT got %h want %h", r_T, fmul(x, y));
        end
`endif
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        nvec++;
        if (extra !== 0) begin
            nmis++;
            $display("FAIL cap_single got %0d extra busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [319:0] x, y, z, t;
        @(negedge clk);
        start = 1'b1;
        p_X = 320'd11; p_Y = 320'd13; p_Z = 320'd17; p_T = 320'd19;
        @(posedge clk);
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            start = 1'b0;
            mif.mul_ack = 1'b1;
            mif.mul_r = fmul(mif.mul_a, mif.mul_b);
            @(posedge clk);
        end
        @(negedge clk);
        mif.mul_ack = 1'b0;
        reset = 1'b0;
        #1;
        nvec++;
        if (mif.mul_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            nmis++;
            $display("FAIL rstmid_ctl got req=%b busy=%b want 0 0",
                     mif.mul_req, busy);
        end
        nvec++;
        if (r_X !== '0 || r_Y !== '0 || r_Z !== '0 || r_T !== '0) begin
            nmis++;
            $display("FAIL rstmid_r got rX=%h want 0", r_X);
        end
        @(negedge clk);
        reset = 1'b1;
        mif.mul_ack = 1'b1;
        mif.mul_r = rnd320();
        @(negedge clk);
        mif.mul_ack = 1'b0;
        nvec++;
        if (busy !== 1'b0 || mif.mul_req !== 1'b0 || r_X !== '0) begin
            nmis++;
            $display("FAIL rstmid_stray got busy=%b req=%b want 0 0",
                     busy, mif.mul_req);
        end
        x = rnd320(); y = rnd320(); z = rnd320(); t = rnd320();
        drive_conv(x, y, z, t, 2, 2, 2, 2, 0);
        nvec++;
        if (o_to || r_X !== fmul(x, t) || r_Z !== fmul(z, t)) begin
            nmis++;
            $display("FAIL rstmid_restart got rX=%h want %h", r_X, fmul(x, t));
        end
    endtask

    task automatic test_back_to_back();
        logic [319:0] x, y, z, t;
        logic [319:0] ax;
        x = rnd320(); y = rnd320(); z = rnd320(); t = rnd320();
        drive_conv(320'd4, 320'd6, 320'd8, 320'd10, 1, 1, 1, 1, 0);
        ax = fmul(320'd4, 320'd10);
        nvec++;
        if (o_to || r_X !== ax) begin
            nmis++;
            $display("FAIL b2b_first got %0d want %0d", r_X, ax);
        end
        drive_conv(x, y, z, t, 2, 1, 3, 1, 0);
        nvec++;
        if (o_busy0 !== 0) begin
            nmis++;
            $display("FAIL b2b_busy got %0d want 0 after done", o_busy0);
        end
        nvec++;
        if (o_to || o_first !== 1) begin
            nmis++;
            $display("FAIL b2b_accept got req@%0d want 1", o_first);
        end
        nvec++;
        if (o_rchg) begin
            nmis++;
            $display("FAIL b2b_hold got r_* changed before second done want held");
        end
        nvec++;
        if (r_X !== fmul(x, t) || r_Y !== fmul(y, z) || r_Z !== fmul(z, t)) begin
            nmis++;
            $display("FAIL b2b_second got rZ=%h want %h", r_Z, fmul(z, t));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_capture();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
